// File: rtl/mb_ascii_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mb_ascii_rx_ctrl
// Purpose  : Receive-side controller for a Modbus ASCII slave. Walks the UART
//            character stream through ':' / hex pairs / CR / LF, decodes the
//            hex pairs into bytes written to an external receive RAM, keeps a
//            running LRC, validates the finished frame and posts it until the
//            consumer acknowledges.
// Ports    : clk, rst_n               - clock, async active-low reset
//            rx_enable                - low aborts reception (except PENDING)
//            rx_valid/rx_byte         - received ASCII character strobe
//            tmr_expired              - inter-character timeout pulse
//            frame_ack                - consumer released the buffer
//            tmr_restart              - restart pulse for the char timer
//            buf_we/buf_addr/buf_wdata- receive buffer write port
//            frame_valid              - one-cycle frame-received event
//            frame_pending            - validated frame awaiting frame_ack
//            frame_len/frame_addr     - decoded length (no LRC) / slave addr
//            err_lrc/err_overrun/err_char - discard reason pulses
// Revision : 1.0 - initial release
// ============================================================================
module mb_ascii_rx_ctrl #(
    parameter logic [7:0] SLAVE_ADDR   = 8'h0A,
    parameter int         BUF_SIZE     = 256,
    parameter int         ADDR_W       = 8,
    parameter logic [7:0] LF_CHAR      = 8'h0A,
    parameter int         PDU_SIZE_MIN = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_enable,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    input  logic              tmr_expired,
    input  logic              frame_ack,
    output logic              tmr_restart,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [7:0]        buf_wdata,
    output logic              frame_valid,
    output logic              frame_pending,
    output logic [ADDR_W:0]   frame_len,
    output logic [7:0]        frame_addr,
    output logic              err_lrc,
    output logic              err_overrun,
    output logic              err_char
);

    localparam logic [7:0]    c_colon    = 8'h3A;
    localparam logic [7:0]    c_cr       = 8'h0D;
    localparam logic [ADDR_W:0] c_buf_size = (ADDR_W+1)'(BUF_SIZE);
    localparam logic [ADDR_W:0] c_pdu_min  = (ADDR_W+1)'(PDU_SIZE_MIN);
    localparam logic [ADDR_W:0] c_one      = (ADDR_W+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RCV      = 3'd1,
        S_WAIT_EOF = 3'd2,
        S_CHECK    = 3'd3,
        S_PENDING  = 3'd4
    } state_t;

    // Bit 4 flags a legal hex character, bits 3:0 carry its value.
    // Letters map via their low nibble: 'A'/'a' low nibble 1 -> 1+9 = 10.
    function automatic logic [4:0] hex_decode(input logic [7:0] ch);
        logic [4:0] r;
        r = 5'd0;
        if (ch >= 8'h30 && ch <= 8'h39)
            r = {1'b1, ch[3:0]};
        else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66))
            r = {1'b1, ch[3:0] + 4'd9};
        return r;
    endfunction

    state_t            r_state, w_state_nxt;
    logic [ADDR_W:0]   r_pos, w_pos_nxt;     // decoded bytes so far; holds BUF_SIZE
    logic [7:0]        r_lrc, w_lrc_nxt;
    logic              r_nib_low, w_nib_low_nxt; // 1: waiting for low nibble
    logic [3:0]        r_hi, w_hi_nxt;
    logic              r_tmr_restart, w_tmr_restart_nxt;
    logic              r_buf_we, w_buf_we_nxt;
    logic [ADDR_W-1:0] r_buf_addr, w_buf_addr_nxt;
    logic [7:0]        r_buf_wdata, w_buf_wdata_nxt;
    logic              r_frame_valid, w_frame_valid_nxt;
    logic              r_frame_pending;
    logic [ADDR_W:0]   r_frame_len, w_frame_len_nxt;
    logic [7:0]        r_frame_addr, w_frame_addr_nxt;
    logic              r_err_lrc, w_err_lrc_nxt;
    logic              r_err_overrun, w_err_overrun_nxt;
    logic              r_err_char, w_err_char_nxt;

    logic [4:0]        w_hex;
    logic [7:0]        w_byte;
    logic              w_len_ok;
    logic              w_addr_ok;

    assign w_hex     = hex_decode(rx_byte);
    assign w_byte    = {r_hi, w_hex[3:0]};
    assign w_len_ok  = (r_pos >= c_pdu_min);
    assign w_addr_ok = (r_frame_addr == SLAVE_ADDR) || (r_frame_addr == 8'h00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_pos_nxt         = r_pos;
        w_lrc_nxt         = r_lrc;
        w_nib_low_nxt     = r_nib_low;
        w_hi_nxt          = r_hi;
        w_frame_len_nxt   = r_frame_len;
        w_frame_addr_nxt  = r_frame_addr;
        w_buf_addr_nxt    = r_buf_addr;
        w_buf_wdata_nxt   = r_buf_wdata;
        w_buf_we_nxt      = 1'b0;
        w_tmr_restart_nxt = 1'b0;
        w_frame_valid_nxt = 1'b0;
        w_err_lrc_nxt     = 1'b0;
        w_err_overrun_nxt = 1'b0;
        w_err_char_nxt    = 1'b0;

        if (r_state == S_PENDING) begin
            // Buffer is owned by the consumer; only the ack releases it.
            if (frame_ack)
                w_state_nxt = S_IDLE;
        end else if (!rx_enable) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (rx_valid && rx_byte == c_colon) begin
                        w_state_nxt       = S_RCV;
                        w_pos_nxt         = '0;
                        w_lrc_nxt         = 8'h00;
                        w_nib_low_nxt     = 1'b0;
                        w_tmr_restart_nxt = 1'b1;
                    end
                end
                S_RCV: begin
                    if (tmr_expired) begin
                        w_state_nxt = S_IDLE;
                    end else if (rx_valid) begin
                        w_tmr_restart_nxt = 1'b1;
                        if (rx_byte == c_colon) begin
                            w_pos_nxt     = '0;
                            w_lrc_nxt     = 8'h00;
                            w_nib_low_nxt = 1'b0;
                        end else if (rx_byte == c_cr) begin
                            w_state_nxt = S_WAIT_EOF;
                        end else if (w_hex[4]) begin
                            if (!r_nib_low) begin
                                w_hi_nxt      = w_hex[3:0];
                                w_nib_low_nxt = 1'b1;
                            end else begin
                                w_nib_low_nxt = 1'b0;
                                if (r_pos < c_buf_size) begin
                                    w_buf_we_nxt    = 1'b1;
                                    w_buf_addr_nxt  = r_pos[ADDR_W-1:0];
                                    w_buf_wdata_nxt = w_byte;
                                    w_pos_nxt       = r_pos + c_one;
                                    w_lrc_nxt       = r_lrc + w_byte;
                                    if (r_pos == '0)
                                        w_frame_addr_nxt = w_byte;
                                end else begin
                                    w_err_overrun_nxt = 1'b1;
                                    w_state_nxt       = S_IDLE;
                                end
                            end
                        end else begin
                            w_err_char_nxt = 1'b1;
                            w_state_nxt    = S_IDLE;
                        end
                    end
                end
                S_WAIT_EOF: begin
                    if (tmr_expired) begin
                        w_state_nxt = S_IDLE;
                    end else if (rx_valid) begin
                        w_tmr_restart_nxt = 1'b1;
                        if (rx_byte == LF_CHAR) begin
                            w_state_nxt = S_CHECK;
                        end else if (rx_byte == c_colon) begin
                            w_state_nxt   = S_RCV;
                            w_pos_nxt     = '0;
                            w_lrc_nxt     = 8'h00;
                            w_nib_low_nxt = 1'b0;
                        end else begin
                            w_err_char_nxt = 1'b1;
                            w_state_nxt    = S_IDLE;
                        end
                    end
                end
                S_CHECK: begin
                    if (w_len_ok && !r_nib_low && r_lrc == 8'h00 && w_addr_ok) begin
                        w_state_nxt       = S_PENDING;
                        w_frame_valid_nxt = 1'b1;
                        w_frame_len_nxt   = r_pos - c_one;
                    end else begin
                        // Framing faults win over LRC; foreign address is silent.
                        w_state_nxt = S_IDLE;
                        if (!w_len_ok || r_nib_low)
                            w_err_char_nxt = 1'b1;
                        else if (r_lrc != 8'h00)
                            w_err_lrc_nxt = 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos           <= '0;
            r_lrc           <= 8'h00;
            r_nib_low       <= 1'b0;
            r_hi            <= 4'h0;
            r_tmr_restart   <= 1'b0;
            r_buf_we        <= 1'b0;
            r_buf_addr      <= '0;
            r_buf_wdata     <= 8'h00;
            r_frame_valid   <= 1'b0;
            r_frame_pending <= 1'b0;
            r_frame_len     <= '0;
            r_frame_addr    <= 8'h00;
            r_err_lrc       <= 1'b0;
            r_err_overrun   <= 1'b0;
            r_err_char      <= 1'b0;
        end else begin
            r_pos           <= w_pos_nxt;
            r_lrc           <= w_lrc_nxt;
            r_nib_low       <= w_nib_low_nxt;
            r_hi            <= w_hi_nxt;
            r_tmr_restart   <= w_tmr_restart_nxt;
            r_buf_we        <= w_buf_we_nxt;
            r_buf_addr      <= w_buf_addr_nxt;
            r_buf_wdata     <= w_buf_wdata_nxt;
            r_frame_valid   <= w_frame_valid_nxt;
            r_frame_pending <= (w_state_nxt == S_PENDING);
            r_frame_len     <= w_frame_len_nxt;
            r_frame_addr    <= w_frame_addr_nxt;
            r_err_lrc       <= w_err_lrc_nxt;
            r_err_overrun   <= w_err_overrun_nxt;
            r_err_char      <= w_err_char_nxt;
        end
    end

    assign tmr_restart   = r_tmr_restart;
    assign buf_we        = r_buf_we;
    assign buf_addr      = r_buf_addr;
    assign buf_wdata     = r_buf_wdata;
    assign frame_valid   = r_frame_valid;
    assign frame_pending = r_frame_pending;
    assign frame_len     = r_frame_len;
    assign frame_addr    = r_frame_addr;
    assign err_lrc       = r_err_lrc;
    assign err_overrun   = r_err_overrun;
    assign err_char      = r_err_char;

endmodule
`default_nettype wire

// File: tb/tb_mb_ascii_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mb_ascii_rx_ctrl
// Purpose  : Self-checking bench for mb_ascii_rx_ctrl. A default instance and
//            a BUF_SIZE=4 instance receive ASCII frames; every expected
//            output event is queued before its stimulus and popped by a
//            negedge monitor when the DUT produces it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mb_ascii_rx_ctrl;

    typedef struct packed {
        logic [2:0]  kind;
        logic [15:0] a;
        logic [15:0] b;
    } ev_t;

    localparam logic [2:0] K_WR  = 3'd0; // a=addr, b=data
    localparam logic [2:0] K_FV  = 3'd1; // a=len,  b=addr
    localparam logic [2:0] K_LRC = 3'd2;
    localparam logic [2:0] K_OVR = 3'd3;
    localparam logic [2:0] K_CHR = 3'd4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_enable = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       tmr_expired = 1'b0;
    logic       frame_ack = 1'b0;
    logic       sel4 = 1'b0;

    logic       rx_valid_m, rx_valid_4;
    assign rx_valid_m = rx_valid & ~sel4;
    assign rx_valid_4 = rx_valid & sel4;

    logic       tmr_restart, buf_we, frame_valid, frame_pending;
    logic [7:0] buf_addr, buf_wdata, frame_addr;
    logic [8:0] frame_len;
    logic       err_lrc, err_overrun, err_char;

    logic       tmr_restart4, buf_we4, frame_valid4, frame_pending4;
    logic [7:0] buf_addr4, buf_wdata4, frame_addr4;
    logic [8:0] frame_len4;
    logic       err_lrc4, err_overrun4, err_char4;

    int   n_tests = 0;
    int   n_fail  = 0;
    ev_t  exp_q[$];
    ev_t  exp4_q[$];
    ev_t  obs_m[$];
    ev_t  obs_4[$];
    ev_t  e_m, e_4;

    always #5 clk = ~clk;

    mb_ascii_rx_ctrl dut (
        .clk(clk), .rst_n(rst_n), .rx_enable(rx_enable), .rx_valid(rx_valid_m),
        .rx_byte(rx_byte), .tmr_expired(tmr_expired), .frame_ack(frame_ack),
        .tmr_restart(tmr_restart), .buf_we(buf_we), .buf_addr(buf_addr),
        .buf_wdata(buf_wdata), .frame_valid(frame_valid),
        .frame_pending(frame_pending), .frame_len(frame_len),
        .frame_addr(frame_addr), .err_lrc(err_lrc), .err_overrun(err_overrun),
        .err_char(err_char)
    );

    mb_ascii_rx_ctrl #(.BUF_SIZE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .rx_enable(rx_enable), .rx_valid(rx_valid_4),
        .rx_byte(rx_byte), .tmr_expired(tmr_expired), .frame_ack(frame_ack),
        .tmr_restart(tmr_restart4), .buf_we(buf_we4), .buf_addr(buf_addr4),
        .buf_wdata(buf_wdata4), .frame_valid(frame_valid4),
        .frame_pending(frame_pending4), .frame_len(frame_len4),
        .frame_addr(frame_addr4), .err_lrc(err_lrc4), .err_overrun(err_overrun4),
        .err_char(err_char4)
    );

    // Scoreboard monitor for the default instance.
    always @(negedge clk) begin
        obs_m.delete();
        if (buf_we)      obs_m.push_back({K_WR, 16'(buf_addr), 16'(buf_wdata)});
        if (frame_valid) obs_m.push_back({K_FV, 16'(frame_len), 16'(frame_addr)});
        if (err_lrc)     obs_m.push_back({K_LRC, 16'd0, 16'd0});
        if (err_overrun) obs_m.push_back({K_OVR, 16'd0, 16'd0});
        if (err_char)    obs_m.push_back({K_CHR, 16'd0, 16'd0});
        foreach (obs_m[i]) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_main unexpected: got kind=%0d a=%0h b=%0h, required none",
                         obs_m[i].kind, obs_m[i].a, obs_m[i].b);
            end else begin
                e_m = exp_q.pop_front();
                if (obs_m[i] !== e_m) begin
                    n_fail++;
                    $display("FAIL sb_main: got kind=%0d a=%0h b=%0h, required kind=%0d a=%0h b=%0h",
                             obs_m[i].kind, obs_m[i].a, obs_m[i].b, e_m.kind, e_m.a, e_m.b);
                end
            end
        end
    end

    // Scoreboard monitor for the BUF_SIZE=4 instance.
    always @(negedge clk) begin
        obs_4.delete();
        if (buf_we4)      obs_4.push_back({K_WR, 16'(buf_addr4), 16'(buf_wdata4)});
        if (frame_valid4) obs_4.push_back({K_FV, 16'(frame_len4), 16'(frame_addr4)});
        if (err_lrc4)     obs_4.push_back({K_LRC, 16'd0, 16'd0});
        if (err_overrun4) obs_4.push_back({K_OVR, 16'd0, 16'd0});
        if (err_char4)    obs_4.push_back({K_CHR, 16'd0, 16'd0});
        foreach (obs_4[i]) begin
            n_tests++;
            if (exp4_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_buf4 unexpected: got kind=%0d a=%0h b=%0h, required none",
                         obs_4[i].kind, obs_4[i].a, obs_4[i].b);
            end else begin
                e_4 = exp4_q.pop_front();
                if (obs_4[i] !== e_4) begin
                    n_fail++;
                    $display("FAIL sb_buf4: got kind=%0d a=%0h b=%0h, required kind=%0d a=%0h b=%0h",
                             obs_4[i].kind, obs_4[i].a, obs_4[i].b, e_4.kind, e_4.a, e_4.b);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [7:0] c);
        rx_byte  = c;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push_ev(input bit to4, input logic [2:0] k, input int a, input int b);
        if (to4) exp4_q.push_back({k, 16'(a), 16'(b)});
        else     exp_q.push_back({k, 16'(a), 16'(b)});
    endtask

    // n bytes packed MSB-first, written from address base upward.
    task automatic push_wrs(input bit to4, input int base, input int n, input logic [63:0] d);
        for (int k = 0; k < n; k++) push_ev(to4, K_WR, base + k, int'(d[8*(n-1-k) +: 8]));
    endtask

    task automatic ack();
        frame_ack = 1'b1;
        @(posedge clk); #1;
        frame_ack = 1'b0;
    endtask

    localparam logic [63:0] FRM_OK = 64'h0A0300000001F2;

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        n_tests++;
        if ({tmr_restart, buf_we, buf_addr, buf_wdata, frame_valid, frame_pending,
             frame_len, frame_addr, err_lrc, err_overrun, err_char} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %0h, required 0",
                     {tmr_restart, buf_we, buf_addr, buf_wdata, frame_valid, frame_pending,
                      frame_len, frame_addr, err_lrc, err_overrun, err_char});
        end
        n_tests++;
        if ({buf_we4, frame_pending4, frame_len4, err_overrun4} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs4: got %0h, required 0",
                     {buf_we4, frame_pending4, frame_len4, err_overrun4});
        end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_valid_frame();
        push_wrs(0, 0, 7, FRM_OK);
        push_ev(0, K_FV, 6, 8'h0A);
        send(8'h3A);
        n_tests++;
        if (tmr_restart !== 1'b1) begin
            n_fail++; $display("FAIL tmr_restart_on_colon: got %b, required 1", tmr_restart);
        end
        send_str("0A0300000001F2\r\n");
        n_tests++;
        if (frame_valid !== 1'b0) begin
            n_fail++; $display("FAIL fv_latency_early: got %b, required 0", frame_valid);
        end
        idle(1);
        n_tests++;
        if ({frame_valid, frame_pending, frame_len, frame_addr} !== {1'b1, 1'b1, 9'd6, 8'h0A}) begin
            n_fail++;
            $display("FAIL fv_post: got fv=%b pend=%b len=%0d addr=%0h, required 1 1 6 0a",
                     frame_valid, frame_pending, frame_len, frame_addr);
        end
        idle(4);
        n_tests++;
        if ({frame_valid, frame_pending, tmr_restart} !== 3'b010) begin
            n_fail++;
            $display("FAIL pending_hold: got fv=%b pend=%b tmr=%b, required 0 1 0",
                     frame_valid, frame_pending, tmr_restart);
        end
        ack();
        n_tests++;
        if (frame_pending !== 1'b0) begin
            n_fail++; $display("FAIL pending_clear: got %b, required 0", frame_pending);
        end
        idle(2);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL valid_frame_drain: got %0d left, required 0", exp_q.size());
        end
    endtask

    task automatic test_lrc_addr();
        push_wrs(0, 0, 7, 64'h0A0300000001F3);
        push_ev(0, K_LRC, 0, 0);
        send_str(":0A0300000001F3\r\n");
        idle(3);
        push_wrs(0, 0, 7, 64'h0B0300000001F1);
        send_str(":0B0300000001F1\r\n");
        idle(3);
        n_tests++;
        if (frame_pending !== 1'b0) begin
            n_fail++; $display("FAIL foreign_addr_pending: got %b, required 0", frame_pending);
        end
        push_wrs(0, 0, 7, 64'h000300000001FC);
        push_ev(0, K_FV, 6, 8'h00);
        send_str(":000300000001FC\r\n");
        idle(2);
        n_tests++;
        if ({frame_pending, frame_addr} !== {1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL broadcast: got pend=%b addr=%0h, required 1 00", frame_pending, frame_addr);
        end
        ack();
        idle(2);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL lrc_addr_drain: got %0d left, required 0", exp_q.size());
        end
    endtask

    task automatic test_restart();
        push_wrs(0, 0, 2, 64'h0A03);
        push_wrs(0, 0, 7, FRM_OK);
        push_ev(0, K_FV, 6, 8'h0A);
        send_str(":0A03:0a0300000001f2\r\n");
        idle(2);
        n_tests++;
        if ({frame_pending, frame_len} !== {1'b1, 9'd6}) begin
            n_fail++;
            $display("FAIL restart_len: got pend=%b len=%0d, required 1 6", frame_pending, frame_len);
        end
        ack();
        idle(2);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL restart_drain: got %0d left, required 0", exp_q.size());
        end
    endtask

    task automatic test_overrun();
        sel4 = 1'b1;
        push_wrs(1, 0, 4, 64'h0A030000);
        push_ev(1, K_OVR, 0, 0);
        send_str(":0A03000000\r\n");
        idle(3);
        // Exactly-full frame is still accepted.
        push_wrs(1, 0, 4, 64'h0A0301F2);
        push_ev(1, K_FV, 3, 8'h0A);
        send_str(":0A0301F2\r\n");
        idle(2);
        n_tests++;
        if ({frame_pending4, frame_len4} !== {1'b1, 9'd3}) begin
            n_fail++;
            $display("FAIL full_buf4: got pend=%b len=%0d, required 1 3", frame_pending4, frame_len4);
        end
        ack();
        idle(2);
        sel4 = 1'b0;
        n_tests++;
        if (exp4_q.size() != 0) begin
            n_fail++; $display("FAIL overrun_drain: got %0d left, required 0", exp4_q.size());
        end
    endtask

    task automatic test_abort();
        // Timeout wins over a ':' in the same cycle; trailing hex is ignored.
        push_wrs(0, 0, 2, 64'h0A03);
        send_str(":0A03");
        tmr_expired = 1'b1;
        send(8'h3A);
        tmr_expired = 1'b0;
        send_str("0A0300\r\n");
        push_wrs(0, 0, 7, FRM_OK);
        push_ev(0, K_FV, 6, 8'h0A);
        send_str(":0A0300000001F2\r\n");
        idle(2);
        ack();
        // Receiver disable aborts the frame the same way.
        push_wrs(0, 0, 2, 64'h0A03);
        send_str(":0A03");
        rx_enable = 1'b0;
        idle(1);
        rx_enable = 1'b1;
        send_str("0300\r\n");
        push_wrs(0, 0, 7, FRM_OK);
        push_ev(0, K_FV, 6, 8'h0A);
        send_str(":0A0300000001F2\r\n");
        idle(2);
        n_tests++;
        if (frame_pending !== 1'b1) begin
            n_fail++; $display("FAIL abort_recover: got pend=%b, required 1", frame_pending);
        end
        ack();
        idle(2);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL abort_drain: got %0d left, required 0", exp_q.size());
        end
    endtask

    task automatic test_char_err();
        push_wrs(0, 0, 1, 64'h0A);
        push_ev(0, K_CHR, 0, 0);
        send_str(":0A0G03\r\n");
        push_wrs(0, 0, 2, 64'h0A03);
        push_ev(0, K_CHR, 0, 0);
        send_str(":0A030\r\n");
        idle(2);
        push_wrs(0, 0, 1, 64'h0A);
        push_ev(0, K_CHR, 0, 0);
        send_str(":0A\r\n");
        idle(2);
        push_wrs(0, 0, 7, FRM_OK);
        push_ev(0, K_CHR, 0, 0);
        send_str(":0A0300000001F2\rX");
        idle(3);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL char_err_drain: got %0d left, required 0", exp_q.size());
        end
    endtask

    task automatic test_pending_drop();
        push_wrs(0, 0, 7, FRM_OK);
        push_ev(0, K_FV, 6, 8'h0A);
        send_str(":0A0300000001F2\r\n");
        idle(1);
        send_str(":0A0300000001F2\r\n");
        rx_enable = 1'b0;
        idle(1);
        rx_enable = 1'b1;
        n_tests++;
        if (frame_pending !== 1'b1) begin
            n_fail++; $display("FAIL pending_drop_hold: got %b, required 1", frame_pending);
        end
        // Ack together with ':' - the ':' must not start a frame.
        frame_ack = 1'b1;
        send(8'h3A);
        frame_ack = 1'b0;
        n_tests++;
        if (frame_pending !== 1'b0) begin
            n_fail++; $display("FAIL ack_with_colon: got pend=%b, required 0", frame_pending);
        end
        send_str("0A03\r\n");
        idle(3);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL pending_drop_drain: got %0d left, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_midframe();
        push_wrs(0, 0, 1, 64'h0A);
        send_str(":0A0");
        send(8'h33);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({buf_we, tmr_restart, buf_addr, buf_wdata} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got we=%b tmr=%b addr=%0h data=%0h, required 0",
                     buf_we, tmr_restart, buf_addr, buf_wdata);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_str("0A03\r\n");
        push_wrs(0, 0, 7, FRM_OK);
        push_ev(0, K_FV, 6, 8'h0A);
        send_str(":0A0300000001F2\r\n");
        idle(2);
        ack();
        idle(2);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL reset_midframe_drain: got %0d left, required 0", exp_q.size());
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_valid_frame();
        test_lrc_addr();
        test_restart();
        test_overrun();
        test_abort();
        test_char_err();
        test_pending_drop();
        test_reset_midframe();
        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mb_ascii_rx_ctrl.md
Name: mb_ascii_rx_ctrl

Overview:
Receive-side controller for the Modbus ASCII slave.
- Sequences the UART receive byte stream through the frame state machine: ':' start, hex-nibble pairs, CR, LF.
- Decodes nibble pairs into binary bytes, writes them into the external receive buffer RAM and accumulates the LRC.
- Validates length, LRC and slave address, then posts a frame-received event and holds it until the event/poll logic acknowledges it.

Parameters:
SLAVE_ADDR, 8'h0A, this slave's Modbus address; address 8'h00 (broadcast) is always accepted.
BUF_SIZE, 256, receive buffer capacity in decoded bytes (including the LRC byte).
ADDR_W, 8, buffer address width; BUF_SIZE <= 2**ADDR_W.
LF_CHAR, 8'h0A, end-of-frame character following CR (8'h0D).
PDU_SIZE_MIN, 3, minimum decoded bytes (address, function, LRC).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_enable  in  1  receiver enable from the Modbus core; low aborts reception
rx_valid  in  1  one-cycle strobe, rx_byte valid
rx_byte  in  8  received ASCII character
tmr_expired  in  1  inter-character timeout pulse from porttimer
frame_ack  in  1  event consumer has taken the frame; releases the buffer
tmr_restart  out  1  pulse to restart porttimer on every accepted character in RCV/WAIT_EOF
buf_we  out  1  buffer write strobe
buf_addr  out  ADDR_W  buffer write address
buf_wdata  out  8  decoded byte
frame_valid  out  1  one-cycle EV_FRAME_RECEIVED post
frame_pending  out  1  high while a validated frame awaits frame_ack
frame_len  out  ADDR_W+1  decoded bytes excluding LRC; valid while frame_pending
frame_addr  out  8  received slave address; valid while frame_pending
err_lrc  out  1  pulse: frame discarded for bad LRC
err_overrun  out  1  pulse: buffer overflow, frame discarded
err_char  out  1  pulse: illegal character inside frame

Behaviour:
- Reset: state=IDLE, pos=0, lrc=0, nibble=HIGH. All outputs 0.
- All outputs are registered. Per-cycle priority: rx_enable low > tmr_expired > rx_valid. Any rx_valid byte in a cycle taken by a higher-priority event is discarded.
- rx_enable low: state returns to IDLE from any state except PENDING. PENDING is left only via frame_ack.
- tmr_expired in RCV or WAIT_EOF -> IDLE, no error pulse.
- Hex decode: '0'-'9', 'A'-'F' and 'a'-'f' are legal.
- IDLE: rx_byte==':' -> RCV, with pos=0, lrc=0, nibble=HIGH. All other bytes are ignored.
- RCV:
  - ':' -> restart (pos=0, lrc=0, nibble=HIGH); stay in RCV.
  - 8'h0D -> WAIT_EOF.
  - Hex char with nibble=HIGH -> latch high nibble; nibble=LOW.
  - Hex char with nibble=LOW -> byte={hi,lo}; nibble=HIGH.
    - If pos<BUF_SIZE: next cycle buf_we=1, buf_addr=pos, buf_wdata=byte; pos+=1; lrc+=byte (mod 256); when pos==0 also capture frame_addr=byte.
    - Else: err_overrun pulse -> IDLE.
  - Any other char -> err_char pulse -> IDLE.
- WAIT_EOF:
  - LF_CHAR -> CHECK.
  - ':' -> RCV restart.
  - Other -> err_char pulse -> IDLE.
- CHECK (exactly one cycle):
  - Pass requires all of: pos>=PDU_SIZE_MIN, nibble==HIGH, lrc==8'h00, frame_addr in {SLAVE_ADDR, 8'h00}.
  - Pass -> PENDING; frame_valid=1 for that cycle; frame_len=pos-1.
  - Fail -> IDLE. err_lrc pulses only when the length and nibble checks pass but lrc!=0. Address mismatch is silent. Odd nibble count or short frame is reported via err_char.
- PENDING: frame_pending=1; all rx_valid bytes are dropped and the buffer is not written. frame_ack -> IDLE and frame_pending=0 on the next cycle.
- Latency:
  - buf_we: 1 cycle after the low-nibble strobe.
  - frame_valid: 2 cycles after the LF strobe (LF -> CHECK, CHECK -> PENDING).
- tmr_restart pulses 1 cycle after any rx_valid accepted in IDLE(':'), RCV or WAIT_EOF.
- pos is ADDR_W+1 bits so it can hold BUF_SIZE exactly; the buffer address wrap is never reached because overflow aborts first.
- Reset mid-frame: immediate IDLE, all outputs 0; buffer contents undefined.

Test Plan:
- Valid frame ":0A0300000001F2\r\n": buf writes 0A,03,00,00,00,01,F2 at addr 0-6; frame_valid 2 cycles after LF; frame_len=6, frame_addr=0A; frame_pending holds until frame_ack, then clears the next cycle.
- LRC error ":0A0300000001F3\r\n": err_lrc pulse; no frame_valid. Foreign address ":0B0300000001F1\r\n": no pulse at all. Broadcast ":000300000001FC\r\n": frame_valid, frame_addr=00.
- Mid-frame restart ":0A03:0a0300000001f2\r\n" (lowercase hex): a single frame_valid; second sequence rewritten from addr 0; frame_len=6.
- BUF_SIZE=4, frame ":0A03000000\r\n": err_overrun on the 5th decoded byte; state IDLE; no frame_valid.
- tmr_expired after ":0A03": state IDLE; a following complete valid frame is accepted normally. rx_enable low mid-frame behaves the same.
- While frame_pending, inject a full valid frame: no buf_we, no frame_valid. Assert frame_ack and rx_valid ':' in the same cycle: ':' is ignored and the state becomes IDLE.
